// File: rtl/adc_sequencer_pkg.sv
// rtl/adc_sequencer_pkg.sv - shared types and constants for the ADC conversion sequencer
package ravenna_adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POWERUP,
    S_SELECT,
    S_CONVERT,
    S_WAIT_EOC,
    S_STORE,
    S_INTERVAL
  } adc_seq_state_t;

  localparam int ADC_NCH = 2;
  localparam int ADC_RES = 10;

  // Status bit positions as seen by the bus register block
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_IRQ_BIT     = 1;
  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_W           = 3;

endpackage

// File: rtl/adc_sequencer_if.sv
// rtl/adc_sequencer_if.sv - control/data pins between the sequencer and the SAR ADC macro
interface adc_sequencer_if #(
  parameter int NCH = 2,
  parameter int RES = 10
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          adc_ena;
  logic [CW-1:0] adc_sel;
  logic          adc_convert;
  logic          adc_eoc;
  logic [RES-1:0] adc_data;

  modport master (output adc_ena, adc_sel, adc_convert, input adc_eoc, adc_data);
  modport slave  (input adc_ena, adc_sel, adc_convert, output adc_eoc, adc_data);
endinterface

// File: rtl/adc_seq_chan_pick.sv
// rtl/adc_seq_chan_pick.sv - finds the lowest enabled channel (i_first) or the next one above i_cur
module adc_seq_chan_pick #(
  parameter int NCH = 2,
  parameter int CW  = 1
) (
  input  logic [NCH-1:0] i_mask,
  input  logic [CW-1:0]  i_cur,
  input  logic           i_first,
  output logic [CW-1:0]  o_idx,
  output logic           o_found
);

  // Descending scan so the lowest qualifying index is the last one written
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_idx   = CW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - scans enabled ADC channels, latches per-channel results, flags overrun/timeout
module adc_sequencer
  import ravenna_adc_pkg::*;
#(
  parameter int NCH     = ADC_NCH,
  parameter int RES     = ADC_RES,
  parameter int SETTLE  = 16,
  parameter int MUXWAIT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_en,
  input  logic [NCH-1:0]     cfg_chmask,
  input  logic               cfg_cont,
  input  logic [15:0]        cfg_interval,
  input  logic               start,
  input  logic [NCH-1:0]     rd_clr,
  adc_sequencer_if.master    adc,
  output logic [NCH*RES-1:0] result,
  output logic [NCH-1:0]     result_valid,
  output logic [NCH-1:0]     overrun,
  output logic               busy,
  output logic               irq,
  output logic               timeout_err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  adc_seq_state_t r_state, w_next;
  logic [15:0]        r_cnt;
  logic [CW-1:0]      r_ch;
  logic [RES-1:0]     r_data;
  logic               r_ena, r_conv, r_busy, r_irq, r_tmo;
  logic [NCH*RES-1:0] r_result;
  logic [NCH-1:0]     r_valid, r_ovr;

  logic [CW-1:0] w_first_idx, w_next_idx, w_ch_val;
  logic          w_first_found, w_next_found;
  logic          w_ch_load, w_step, w_store, w_irq, w_tmo_set;

  adc_seq_chan_pick #(.NCH(NCH), .CW(CW)) u_pick_first (
    .i_mask (cfg_chmask),
    .i_cur  (r_ch),
    .i_first(1'b1),
    .o_idx  (w_first_idx),
    .o_found(w_first_found)
  );

  adc_seq_chan_pick #(.NCH(NCH), .CW(CW)) u_pick_next (
    .i_mask (cfg_chmask),
    .i_cur  (r_ch),
    .i_first(1'b0),
    .o_idx  (w_next_idx),
    .o_found(w_next_found)
  );

  always_comb begin
    w_next    = r_state;
    w_ch_load = 1'b0;
    w_ch_val  = r_ch;
    w_step    = 1'b0;
    w_store   = 1'b0;
    w_irq     = 1'b0;
    w_tmo_set = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (start && cfg_en && (|cfg_chmask)) w_next = S_POWERUP;
      S_POWERUP, S_INTERVAL:
        if ((r_state == S_POWERUP && r_cnt == 16'(SETTLE - 1)) ||
            (r_state == S_INTERVAL && ({1'b0, r_cnt} + 17'd1) >= {1'b0, cfg_interval})) begin
          w_next    = w_first_found ? S_SELECT : S_IDLE;
          w_ch_load = w_first_found;
          w_ch_val  = w_first_idx;
        end
      S_SELECT:
        if (r_cnt == 16'(MUXWAIT - 1)) w_next = S_CONVERT;
      S_CONVERT:
        w_next = S_WAIT_EOC;
      S_WAIT_EOC:
        if (adc.adc_eoc) begin
          w_next = S_STORE;
        end else if (r_cnt == 16'(TIMEOUT - 1)) begin
          w_tmo_set = 1'b1;
          w_step    = 1'b1;
        end
      S_STORE: begin
        w_store = 1'b1;
        w_step  = 1'b1;
      end
      default:
        w_next = S_IDLE;
    endcase

    // Channel step after a store or a skipped (timed-out) channel
    if (w_step) begin
      if (w_next_found) begin
        w_next    = S_SELECT;
        w_ch_load = 1'b1;
        w_ch_val  = w_next_idx;
      end else begin
        w_irq  = 1'b1;
        w_next = cfg_cont ? S_INTERVAL : S_IDLE;
      end
    end

    if (!cfg_en) begin
      w_next    = S_IDLE;
      w_store   = 1'b0;
      w_irq     = 1'b0;
      w_tmo_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ch     <= '0;
      r_data   <= '0;
      r_ena    <= 1'b0;
      r_conv   <= 1'b0;
      r_busy   <= 1'b0;
      r_irq    <= 1'b0;
      r_tmo    <= 1'b0;
      r_result <= '0;
      r_valid  <= '0;
      r_ovr    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (w_ch_load) r_ch <= w_ch_val;
      if (r_state == S_WAIT_EOC && adc.adc_eoc) r_data <= adc.adc_data;
      r_ena  <= (w_next != S_IDLE);
      r_busy <= (w_next != S_IDLE);
      r_conv <= (w_next == S_CONVERT);
      r_irq  <= w_irq;
      if (w_tmo_set) r_tmo <= 1'b1;
      else if (start && r_state == S_IDLE) r_tmo <= 1'b0;
      // A store beats a simultaneous read-clear; the clear still suppresses overrun
      for (int i = 0; i < NCH; i++) begin
        if (w_store && r_ch == CW'(i)) begin
          r_result[i*RES +: RES] <= r_data;
          r_valid[i]             <= 1'b1;
          r_ovr[i]               <= rd_clr[i] ? 1'b0 : (r_ovr[i] | r_valid[i]);
        end else if (rd_clr[i]) begin
          r_valid[i] <= 1'b0;
          r_ovr[i]   <= 1'b0;
        end
      end
    end
  end

  assign adc.adc_ena     = r_ena;
  assign adc.adc_sel     = r_ch;
  assign adc.adc_convert = r_conv;
  assign result          = r_result;
  assign result_valid    = r_valid;
  assign overrun         = r_ovr;
  assign busy            = r_busy;
  assign irq             = r_irq;
  assign timeout_err     = r_tmo;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - directed and randomized self-checking bench for adc_sequencer
module tb_adc_sequencer;
  import ravenna_adc_pkg::*;

  localparam int NCH = 2, RES = 10, SETTLE = 16, MUXWAIT = 2, TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_chmask = 2'b00;
  logic        cfg_cont = 1'b0;
  logic [15:0] cfg_interval = 16'd0;
  logic        start = 1'b0;
  logic [1:0]  rd_clr = 2'b00;
  wire  [19:0] result;
  wire  [1:0]  result_valid, overrun;
  wire         busy, irq, timeout_err;
  logic [STAT_W-1:0] stat;

  adc_sequencer_if #(.NCH(NCH), .RES(RES)) adc_bus ();

  adc_sequencer #(.NCH(NCH), .RES(RES), .SETTLE(SETTLE), .MUXWAIT(MUXWAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .cfg_en(cfg_en), .cfg_chmask(cfg_chmask), .cfg_cont(cfg_cont),
    .cfg_interval(cfg_interval), .start(start), .rd_clr(rd_clr), .adc(adc_bus),
    .result(result), .result_valid(result_valid), .overrun(overrun), .busy(busy), .irq(irq),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    stat = '0;
    stat[STAT_BUSY_BIT]    = busy;
    stat[STAT_IRQ_BIT]     = irq;
    stat[STAT_TIMEOUT_BIT] = timeout_err;
  end

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int eoc_cyc = -1, clr0_cyc = -1, delay = 20;
  logic [9:0] eoc_val;
  logic [9:0] data_for [2];
  bit drop_ch0 = 1'b0;
  int irq_cnt = 0;
  int irq_cyc[$], conv_cyc[$], conv_sel[$];
  logic [9:0] m_res [2];
  logic [1:0] m_valid = 2'b00, m_ovr = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: observe DUT after the edge, then play the ADC macro for the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (irq) begin irq_cnt++; irq_cyc.push_back(cyc); end
    if (adc_bus.adc_convert) begin
      conv_cyc.push_back(cyc);
      conv_sel.push_back(int'(adc_bus.adc_sel));
      if (!(drop_ch0 && adc_bus.adc_sel == 1'b0)) begin
        eoc_cyc = cyc + delay;
        eoc_val = data_for[adc_bus.adc_sel];
      end
    end
    adc_bus.adc_eoc  = (cyc == eoc_cyc);
    adc_bus.adc_data = (cyc == eoc_cyc) ? eoc_val : 10'($urandom);
    if (clr0_cyc >= 0) rd_clr[0] = (cyc == clr0_cyc);
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int limit);
    int n0 = irq_cnt;
    int k = 0;
    while (irq_cnt == n0 && k < limit) begin tick(); k++; end
    chk({tag, "_irq_seen"}, 64'(irq_cnt != n0), 64'd1);
  endtask

  task automatic wait_conv(input string tag, input int limit);
    int n0 = conv_cyc.size();
    int k = 0;
    while (conv_cyc.size() == n0 && k < limit) begin tick(); k++; end
    chk({tag, "_conv_seen"}, 64'(conv_cyc.size() != n0), 64'd1);
  endtask

  task automatic clear_all();
    rd_clr = 2'b11;
    tick();
    rd_clr = 2'b00;
    m_valid = 2'b00;
    m_ovr = 2'b00;
  endtask

  task automatic m_store(input int ch, input logic [9:0] v, input bit clr);
    m_ovr[ch]   = clr ? 1'b0 : (m_ovr[ch] | m_valid[ch]);
    m_valid[ch] = 1'b1;
    m_res[ch]   = v;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_result"}, 64'(result), 64'({m_res[1], m_res[0]}));
    chk({tag, "_valid"}, 64'(result_valid), 64'(m_valid));
    chk({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
  endtask

  function automatic int scan_end(input int s, input logic [1:0] mask, input int d);
    return s + SETTLE + (int'(mask[0]) + int'(mask[1])) * (MUXWAIT + 2 + d) + 1;
  endfunction

  initial begin
    int s, i1, i2, n0;
    logic [1:0] mk;
    adc_bus.adc_eoc = 1'b0;
    adc_bus.adc_data = '0;
    m_res[0] = '0;
    m_res[1] = '0;

    repeat (3) tick();
    chk("rst_outputs", 64'({adc_bus.adc_ena, adc_bus.adc_convert, adc_bus.adc_sel, busy, irq, timeout_err}), 64'd0);
    chk("rst_status", 64'(stat), 64'd0);
    chk_regs("rst");
    resetn = 1'b1;
    cfg_en = 1'b1;
    tick();

    // Single scan, both channels
    cfg_chmask = 2'b11;
    data_for[0] = 10'h155;
    data_for[1] = 10'h2AA;
    pulse_start(s);
    chk("single_busy_rise", 64'(busy), 64'd1);
    wait_irq("single", 400);
    chk("single_first_conv", 64'(conv_cyc[0]), 64'(s + SETTLE + MUXWAIT + 1));
    chk("single_irq_cycle", 64'(irq_cyc[$]), 64'(scan_end(s, 2'b11, delay)));
    chk("single_ena_off", 64'({adc_bus.adc_ena, busy}), 64'd0);
    m_store(0, 10'h155, 1'b0);
    m_store(1, 10'h2AA, 1'b0);
    chk_regs("single");
    repeat (30) tick();
    chk("single_one_irq", 64'(irq_cnt), 64'd1);

    // Mask 2'b10 only converts channel 1
    clear_all();
    cfg_chmask = 2'b10;
    data_for[1] = 10'($urandom);
    n0 = conv_cyc.size();
    pulse_start(s);
    wait_irq("mask10", 400);
    chk("mask10_nconv", 64'(conv_cyc.size() - n0), 64'd1);
    chk("mask10_sel", 64'(conv_sel[$]), 64'd1);
    m_store(1, data_for[1], 1'b0);
    chk_regs("mask10");

    // Mask zero: start is ignored
    cfg_chmask = 2'b00;
    pulse_start(s);
    for (int k = 0; k < 4; k++) begin
      chk("mask0_busy", 64'(busy), 64'd0);
      tick();
    end

    // Continuous mode with interval 50, no read-clear between scans
    clear_all();
    cfg_chmask = 2'b11;
    cfg_cont = 1'b1;
    cfg_interval = 16'd50;
    data_for[0] = 10'($urandom);
    data_for[1] = 10'($urandom);
    pulse_start(s);
    wait_irq("cont1", 400);
    i1 = irq_cyc[$];
    m_store(0, data_for[0], 1'b0);
    m_store(1, data_for[1], 1'b0);
    chk_regs("cont1");
    data_for[0] = 10'($urandom);
    data_for[1] = 10'($urandom);
    wait_irq("cont2", 400);
    i2 = irq_cyc[$];
    chk("cont_irq_spacing", 64'(i2 - i1), 64'(2 * (MUXWAIT + 2 + delay) + 50));
    m_store(0, data_for[0], 1'b0);
    m_store(1, data_for[1], 1'b0);
    chk_regs("cont2");
    cfg_cont = 1'b0;
    data_for[0] = 10'($urandom);
    data_for[1] = 10'($urandom);
    wait_irq("cont3", 400);
    m_store(0, data_for[0], 1'b0);
    m_store(1, data_for[1], 1'b0);
    chk_regs("cont3");
    tick();
    chk("cont_stop_busy", 64'(busy), 64'd0);

    // Channel 0 never answers: timeout, skip, channel 1 still converts
    clear_all();
    drop_ch0 = 1'b1;
    data_for[1] = 10'($urandom);
    pulse_start(s);
    wait_conv("tmo", 100);
    i1 = conv_cyc[$];
    while (cyc < i1 + TIMEOUT) tick();
    chk("tmo_not_yet", 64'(timeout_err), 64'd0);
    tick();
    chk("tmo_set", 64'(stat[STAT_TIMEOUT_BIT]), 64'd1);
    wait_irq("tmo", 400);
    m_store(1, data_for[1], 1'b0);
    chk_regs("tmo");
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    drop_ch0 = 1'b0;
    data_for[0] = 10'($urandom);
    data_for[1] = 10'($urandom);
    pulse_start(s);
    chk("tmo_cleared", 64'(timeout_err), 64'd0);
    wait_irq("tmo_rescan", 400);
    m_store(0, data_for[0], 1'b0);
    m_store(1, data_for[1], 1'b0);
    chk_regs("tmo_rescan");

    // rd_clr[0] coincident with the channel-0 store
    data_for[0] = 10'($urandom);
    data_for[1] = 10'($urandom);
    pulse_start(s);
    wait_conv("clr", 100);
    clr0_cyc = eoc_cyc + 1;
    wait_irq("clr", 400);
    clr0_cyc = -1;
    rd_clr = 2'b00;
    m_store(0, data_for[0], 1'b1);
    m_store(1, data_for[1], 1'b0);
    chk_regs("clr");

    // cfg_en dropped while waiting for eoc
    delay = 60;
    n0 = irq_cnt;
    pulse_start(s);
    wait_conv("abort", 100);
    repeat (5) tick();
    cfg_en = 1'b0;
    tick();
    chk("abort_idle", 64'({adc_bus.adc_ena, busy}), 64'd0);
    repeat (100) tick();
    chk("abort_no_irq", 64'(irq_cnt), 64'(n0));
    chk_regs("abort");
    cfg_en = 1'b1;
    delay = 20;

    // Asynchronous reset while in SELECT
    pulse_start(s);
    while (cyc < s + SETTLE + 1) tick();
    #2 resetn = 1'b0;
    #1;
    m_valid = 2'b00;
    m_ovr = 2'b00;
    m_res[0] = '0;
    m_res[1] = '0;
    chk("arst_outputs", 64'({adc_bus.adc_ena, adc_bus.adc_convert, adc_bus.adc_sel, busy, irq, timeout_err}), 64'd0);
    chk_regs("arst");
    repeat (2) tick();
    resetn = 1'b1;
    repeat (40) tick();
    chk("arst_no_irq", 64'(irq_cnt), 64'(n0));
    chk("arst_idle", 64'({adc_bus.adc_ena, busy}), 64'd0);

    // Randomized single scans against the model
    for (int it = 0; it < 5; it++) begin
      if ($urandom_range(0, 1) == 1) clear_all();
      mk = 2'($urandom_range(1, 3));
      cfg_chmask = mk;
      delay = int'($urandom_range(1, 40));
      data_for[0] = 10'($urandom);
      data_for[1] = 10'($urandom);
      n0 = conv_cyc.size();
      pulse_start(s);
      wait_irq("rand", 500);
      chk("rand_first_conv", 64'(conv_cyc[n0]), 64'(s + SETTLE + MUXWAIT + 1));
      chk("rand_irq_cycle", 64'(irq_cyc[$]), 64'(scan_end(s, mk, delay)));
      for (int c = 0; c < 2; c++) if (mk[c]) m_store(c, data_for[c], 1'b0);
      chk_regs("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
